// File: rtl/ingress_frame_assembler.sv
// ingress_frame_assembler
// Takes the tagged packet stream from the match cache egress port.
// Each packet is split into a payload and a 2-bit framing tag.
// Frame structure is enforced: orphan DATA/LAST beats are dropped, and a
// frame broken by an unexpected start or by overflow is closed with an
// inserted abort beat. Clean beats are forwarded through a one-entry
// registered output slot.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   ingress_valid/ready/data   tagged packet input ({tag, payload})
//   egress_valid/ready/data    registered payload output
//   egress_first/last/abort    frame markers of the current output beat
//   frame_done        one-cycle pulse, frame closed by LAST/SINGLE
//   frame_error       one-cycle pulse, framing violation detected
//   frame_length      beats of the last completed or aborted frame
//   error_count       saturating framing-error count
module ingress_frame_assembler #(
    parameter  int C_PACKET_WIDTH    = 66,
    parameter  int C_MAX_FRAME_BEATS = 4096,
    localparam int C_DATA_WIDTH      = C_PACKET_WIDTH - 2,
    localparam int C_LEN_WIDTH       = $clog2(C_MAX_FRAME_BEATS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ingress_valid,
    output logic                      ingress_ready,
    input  logic [C_PACKET_WIDTH-1:0] ingress_data,
    output logic                      egress_valid,
    input  logic                      egress_ready,
    output logic [C_DATA_WIDTH-1:0]   egress_data,
    output logic                      egress_first,
    output logic                      egress_last,
    output logic                      egress_abort,
    output logic                      frame_done,
    output logic                      frame_error,
    output logic [C_LEN_WIDTH-1:0]    frame_length,
    output logic [15:0]               error_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FRAME = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    localparam logic [1:0] TAG_DATA   = 2'b00;
    localparam logic [1:0] TAG_FIRST  = 2'b01;
    localparam logic [1:0] TAG_LAST   = 2'b10;
    localparam logic [1:0] TAG_SINGLE = 2'b11;

    localparam logic [C_LEN_WIDTH-1:0] C_ONE_L      = {{(C_LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [C_LEN_WIDTH-1:0] C_MAX_BEATS_L = C_LEN_WIDTH'(C_MAX_FRAME_BEATS);

    state_t                   state_r;
    logic [C_LEN_WIDTH-1:0]   beat_count_r;

    logic [1:0]               tag_s;
    logic [C_DATA_WIDTH-1:0]  payload_s;
    logic                     slot_free_s;
    logic                     is_start_s;
    logic                     legal_s;
    logic                     ready_s;
    logic                     load_s;
    logic [C_DATA_WIDTH-1:0]  ld_data_s;
    logic                     ld_first_s;
    logic                     ld_last_s;
    logic                     ld_abort_s;

    // Saturating 16-bit increment for the error counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

    assign tag_s         = ingress_data[C_PACKET_WIDTH-1:C_PACKET_WIDTH-2];
    assign payload_s     = ingress_data[C_DATA_WIDTH-1:0];
    assign slot_free_s   = ~egress_valid | egress_ready;
    assign is_start_s    = (tag_s == TAG_FIRST) | (tag_s == TAG_SINGLE);
    // Continuation beat that still fits in the frame.
    assign legal_s       = ((tag_s == TAG_DATA) | (tag_s == TAG_LAST)) & (beat_count_r < C_MAX_BEATS_L);
    assign ingress_ready = ready_s;

    // Decode ready and the beat to be loaded into the output slot this cycle.
    always_comb begin
        ready_s    = 1'b0;
        load_s     = 1'b0;
        ld_data_s  = payload_s;
        ld_first_s = 1'b0;
        ld_last_s  = 1'b0;
        ld_abort_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (is_start_s) begin
                    ready_s    = slot_free_s;
                    load_s     = ingress_valid & slot_free_s;
                    ld_first_s = 1'b1;
                    ld_last_s  = (tag_s == TAG_SINGLE);
                end else begin
                    // Orphan continuation beats are swallowed without needing the slot.
                    ready_s = 1'b1;
                end
            end
            ST_FRAME: begin
                if (legal_s) begin
                    ready_s   = slot_free_s;
                    load_s    = ingress_valid & slot_free_s;
                    ld_last_s = (tag_s == TAG_LAST);
                end else begin
                    // The offending beat stays on the input; the slot takes an abort beat instead.
                    ready_s    = 1'b0;
                    load_s     = ingress_valid & slot_free_s;
                    ld_data_s  = {C_DATA_WIDTH{1'b0}};
                    ld_last_s  = 1'b1;
                    ld_abort_s = 1'b1;
                end
            end
            ST_DRAIN: begin
                ready_s = ~is_start_s;
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    // Output slot: load a new beat, release it on handshake, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            egress_valid <= 1'b0;
            egress_data  <= {C_DATA_WIDTH{1'b0}};
            egress_first <= 1'b0;
            egress_last  <= 1'b0;
            egress_abort <= 1'b0;
        end else if (load_s) begin
            egress_valid <= 1'b1;
            egress_data  <= ld_data_s;
            egress_first <= ld_first_s;
            egress_last  <= ld_last_s;
            egress_abort <= ld_abort_s;
        end else if (egress_ready) begin
            egress_valid <= 1'b0;
        end
    end

    // Frame FSM with beat counting and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            beat_count_r <= {C_LEN_WIDTH{1'b0}};
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
            frame_length <= {C_LEN_WIDTH{1'b0}};
            error_count  <= 16'd0;
        end else begin
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ingress_valid & ready_s) begin
                        if (tag_s == TAG_FIRST) begin
                            beat_count_r <= C_ONE_L;
                            state_r      <= ST_FRAME;
                        end else if (tag_s == TAG_SINGLE) begin
                            frame_done   <= 1'b1;
                            frame_length <= C_ONE_L;
                        end else begin
                            frame_error <= 1'b1;
                            error_count <= sat_inc16(error_count);
                        end
                    end
                end
                ST_FRAME: begin
                    if (load_s) begin
                        if (legal_s) begin
                            beat_count_r <= beat_count_r + C_ONE_L;
                            if (tag_s == TAG_LAST) begin
                                frame_done   <= 1'b1;
                                frame_length <= beat_count_r + C_ONE_L;
                                state_r      <= ST_IDLE;
                            end
                        end else begin
                            frame_error  <= 1'b1;
                            frame_length <= beat_count_r;
                            error_count  <= sat_inc16(error_count);
                            // An unexpected start begins a new frame; overflow must skip the rest.
                            state_r      <= is_start_s ? ST_IDLE : ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (ingress_valid & (tag_s != TAG_DATA)) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
